// File: rtl/cic_decim_iq.sv
// cic_decim_iq: dual-channel (I/Q) CIC decimator.
// STAGES registered integrators at the input rate, a shared sample counter
// with a runtime ratio R, and STAGES pipelined comb stages at the output rate.
// Output path: comb result >>> out_shift, then reduction to OUT_W.
// Optional feature macro: CIC_ROUND_SAT_EN adds half-LSB rounding and
// saturation with a sticky sat_flag. Without it the shift floors, the low
// OUT_W bits are kept, and sat_flag stays 0.
module cic_decim_iq #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int STAGES = 5,
  parameter int ACC_W  = 80
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_i,
  input  logic signed [IN_W-1:0]  in_q,
  input  logic [14:0]             dec_ratio,
  input  logic [6:0]              out_shift,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_clk,
  output logic                    sat_flag
);

`ifdef CIC_ROUND_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

  // Optional half-LSB rounding, then arithmetic (floor) shift.
  function automatic logic signed [ACC_W-1:0] scale(
    input logic signed [ACC_W-1:0] v,
    input logic [6:0]              sh
  );
    logic signed [ACC_W-1:0] t;
    t = v;
`ifdef CIC_ROUND_SAT_EN
    if (sh != 7'd0) t = v + (ACC_W'(1) << (sh - 7'd1));
`endif
    return t >>> sh;
  endfunction

  // Reduce a scaled value to OUT_W: clip to range, or keep the low bits.
  function automatic logic signed [OUT_W-1:0] reduce(
    input logic signed [ACC_W-1:0] v
  );
`ifdef CIC_ROUND_SAT_EN
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
`else
    return v[OUT_W-1:0];
`endif
  endfunction

`ifdef CIC_ROUND_SAT_EN
  // True when reduce() would clip this value.
  function automatic logic clipped(input logic signed [ACC_W-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction
`endif

  logic signed [ACC_W-1:0] ext_i, ext_q;
  logic signed [ACC_W-1:0] int_i     [STAGES];
  logic signed [ACC_W-1:0] int_q     [STAGES];
  logic signed [ACC_W-1:0] int_i_nxt [STAGES];
  logic signed [ACC_W-1:0] int_q_nxt [STAGES];

  logic [14:0] r_cur, r_req, r_eff, cnt, cnt_inc;
  logic        r_load;
  logic        wrap, half_hit;

  logic signed [ACC_W-1:0] cap_i_p0, cap_q_p0;
  logic                    vld_p0;

  logic [STAGES-1:0]       vin;
  logic signed [ACC_W-1:0] xin_i    [STAGES];
  logic signed [ACC_W-1:0] xin_q    [STAGES];
  logic signed [ACC_W-1:0] dly_i    [STAGES];
  logic signed [ACC_W-1:0] dly_q    [STAGES];
  logic signed [ACC_W-1:0] cmb_i_p1 [STAGES];
  logic signed [ACC_W-1:0] cmb_q_p1 [STAGES];
  logic [STAGES-1:0]       vld_p1;
  logic [6:0]              sh_p1;

  logic signed [ACC_W-1:0] sc_i_p2, sc_q_p2;
  logic                    vld_p2;

  assign ext_i = {{(ACC_W-IN_W){in_i[IN_W-1]}}, in_i};
  assign ext_q = {{(ACC_W-IN_W){in_q[IN_W-1]}}, in_q};

  // Integrator cascade next-state; each stage adds the previous stage's register.
  always_comb begin
    int_i_nxt[0] = int_i[0] + ext_i;
    int_q_nxt[0] = int_q[0] + ext_q;
    for (int k = 1; k < STAGES; k++) begin
      int_i_nxt[k] = int_i[k] + int_i[k-1];
      int_q_nxt[k] = int_q[k] + int_q[k-1];
    end
  end

  // Integrator registers advance only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        int_i[k] <= '0;
        int_q[k] <= '0;
      end
    end else if (in_valid) begin
      for (int k = 0; k < STAGES; k++) begin
        int_i[k] <= int_i_nxt[k];
        int_q[k] <= int_q_nxt[k];
      end
    end
  end

  // Ratio below 2 is clamped; the first clock after reset uses the live input.
  assign r_req    = (dec_ratio < 15'd2) ? 15'd2 : dec_ratio;
  assign r_eff    = r_load ? r_req : r_cur;
  assign cnt_inc  = cnt + 15'd1;
  assign wrap     = in_valid && (cnt == r_eff - 15'd1);
  assign half_hit = in_valid && !wrap && (cnt_inc == (r_eff >> 1));

  // Sample counter, ratio latch and output-rate square wave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur   <= 15'd2;
      r_load  <= 1'b1;
      cnt     <= '0;
      out_clk <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (r_load || wrap) r_cur <= r_req;
      if (wrap)          cnt <= '0;
      else if (in_valid) cnt <= cnt_inc;
      if (wrap)          out_clk <= 1'b1;
      else if (half_hit) out_clk <= 1'b0;
    end
  end

  // Stage p0: capture the post-update last integrator at each period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_i_p0 <= '0;
      cap_q_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= wrap;
      if (wrap) begin
        cap_i_p0 <= int_i_nxt[STAGES-1];
        cap_q_p0 <= int_q_nxt[STAGES-1];
      end
    end
  end

  // Comb stage inputs: stage 0 from the capture, stage k from stage k-1.
  always_comb begin
    vin      = '0;
    vin[0]   = vld_p0;
    xin_i[0] = cap_i_p0;
    xin_q[0] = cap_q_p0;
    for (int k = 1; k < STAGES; k++) begin
      vin[k]   = vld_p1[k-1];
      xin_i[k] = cmb_i_p1[k-1];
      xin_q[k] = cmb_q_p1[k-1];
    end
  end

  // Stage p1: comb pipeline, one differentiator per clock, delay of one output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        dly_i[k]    <= '0;
        dly_q[k]    <= '0;
        cmb_i_p1[k] <= '0;
        cmb_q_p1[k] <= '0;
      end
      vld_p1 <= '0;
      sh_p1  <= '0;
    end else begin
      vld_p1 <= vin;
      for (int k = 0; k < STAGES; k++) begin
        if (vin[k]) begin
          dly_i[k]    <= xin_i[k];
          dly_q[k]    <= xin_q[k];
          cmb_i_p1[k] <= xin_i[k] - dly_i[k];
          cmb_q_p1[k] <= xin_q[k] - dly_q[k];
        end
      end
      // The shift amount is taken on the clock the last comb stage completes.
      if (vin[STAGES-1]) sh_p1 <= out_shift;
    end
  end

  // Stage p2: rounding and arithmetic shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_i_p2 <= '0;
      sc_q_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1[STAGES-1];
      if (vld_p1[STAGES-1]) begin
        sc_i_p2 <= scale(cmb_i_p1[STAGES-1], sh_p1);
        sc_q_p2 <= scale(cmb_q_p1[STAGES-1], sh_p1);
      end
    end
  end

  // Output stage: width reduction, held between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_i <= reduce(sc_i_p2);
        out_q <= reduce(sc_q_p2);
      end
    end
  end

`ifdef CIC_ROUND_SAT_EN
  // Sticky clip indicator, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag <= 1'b0;
    else if (vld_p2 && (clipped(sc_i_p2) || clipped(sc_q_p2))) sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_cic_decim_iq.sv
// Directed bench for cic_decim_iq (default parameters, either macro setting).
module tb_cic_decim_iq;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 16;
  localparam int STAGES = 5;
  localparam int ACC_W  = 80;
  localparam int LAT    = STAGES + 2;
  localparam int TMO    = 200;

`ifdef CIC_ROUND_SAT_EN
  localparam int EXP_NEG128 = -32768;
  localparam int EXP_SAT    = 1;
`else
  localparam int EXP_NEG128 = 0;
  localparam int EXP_SAT    = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_i = '0;
  logic signed [IN_W-1:0]  in_q = '0;
  logic [14:0]             dec_ratio = 15'd16;
  logic [6:0]              out_shift = 7'd20;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_i, out_q;
  logic                    out_clk, sat_flag;

  cic_decim_iq #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .dec_ratio(dec_ratio), .out_shift(out_shift), .out_valid(out_valid),
    .out_i(out_i), .out_q(out_q), .out_clk(out_clk), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int gap    = 0;
  int phase  = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (gap == 0) in_valid = 1'b0;
    else begin
      phase    = (phase + 1) % gap;
      in_valid = (phase == 0);
    end
  endtask

  task automatic wait_out(output int stamp);
    bit ok;
    ok    = 1'b0;
    stamp = -1;
    for (int t = 0; t < TMO; t++) begin
      tick();
      if (out_valid) begin
        ok    = 1'b1;
        stamp = cyc;
        break;
      end
    end
    chk("out_valid_seen", ok, 1);
  endtask

  task automatic do_reset(input int r, input int sh, input int ii, input int qq,
                          input int g, output int t0);
    tick();
    rst_n = 1'b0; gap = 0; in_valid = 1'b0;
    dec_ratio = 15'(r); out_shift = 7'(sh);
    in_i = IN_W'(ii); in_q = IN_W'(qq);
    repeat (3) tick();
    rst_n = 1'b1; gap = g; phase = 0; in_valid = 1'b1; t0 = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_i"},     out_i,     0);
    chk({tag, "_q"},     out_q,     0);
    chk({tag, "_clk"},   out_clk,   0);
    chk({tag, "_sat"},   sat_flag,  0);
  endtask

  initial begin
    int t0, s, prev, hi;
    logic signed [OUT_W-1:0] neg;

    // Reset state
    in_i = 8'sd1; in_q = 8'sd1;
    repeat (3) tick();
    chk_zero("rst");

    // DC +1, R=16, shift 20: unity after settling, one output per 16 clks
    rst_n = 1'b1; gap = 1; phase = 0; in_valid = 1'b1; t0 = cyc;
    wait_out(s);
    chk("first_latency", s - t0, 16 + LAT);
    prev = s;
    for (int j = 1; j < 10; j++) begin
      wait_out(s);
      chk("interval_r16", s - prev, 16);
      prev = s;
      if (j >= 6) begin
        chk("dc_i", out_i, 1);
        chk("dc_q", out_q, 1);
      end
    end
    hi = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      hi += int'(out_clk);
    end
    chk("out_clk_duty", hi, 8);
    chk("sat_dc", sat_flag, 0);

    // Reset pulsed 10 samples into a period
    wait_out(s);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (4) tick();
    rst_n = 1'b1; t0 = cyc;
    wait_out(s);
    chk("midrst_latency", s - t0, 16 + LAT);

    // Ratio 16 -> 8 written mid-period
    wait_out(s);
    dec_ratio = 15'd8;
    prev = s;
    wait_out(s);
    chk("ratio_cur_16", s - prev, 16);
    prev = s;
    wait_out(s);
    chk("ratio_next_8", s - prev, 8);
    prev = s;
    wait_out(s);
    chk("ratio_next_8b", s - prev, 8);

    // I=+1, Q=-1, R=4, shift 0: Q mirrors I; DC gain 1024
    do_reset(4, 0, 1, -1, 1, t0);
    chk_zero("rst2");
    for (int j = 0; j < 10; j++) begin
      wait_out(s);
      if (j == 0) chk("r4_latency", s - t0, 4 + LAT);
      neg = -out_i;
      chk("q_neg_i", out_q, neg);
      if (j >= 6) chk("r4_gain_i", out_i, 1024);
    end

    // -128, R=4, shift 0: -131072 at full precision
    do_reset(4, 0, -128, -128, 1, t0);
    for (int j = 0; j < 10; j++) begin
      wait_out(s);
      if (j >= 6) begin
        chk("neg128_i", out_i, EXP_NEG128);
        chk("neg128_q", out_q, EXP_NEG128);
        chk("neg128_sat", sat_flag, EXP_SAT);
      end
    end
    repeat (20) tick();
    chk("sat_sticky", sat_flag, EXP_SAT);
    tick();
    rst_n = 1'b0;
    #1;
    chk("sat_cleared", sat_flag, 0);

    // DC +1, R=16, in_valid every 3rd clk
    do_reset(16, 20, 1, 1, 3, t0);
    wait_out(s);
    prev = s;
    for (int j = 1; j < 10; j++) begin
      wait_out(s);
      chk("interval_gap3", s - prev, 48);
      prev = s;
      if (j >= 6) begin
        chk("gap3_i", out_i, 1);
        chk("gap3_q", out_q, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
